// File: rtl/ahb_bus_arbiter_if.sv
// AHB arbiter bus bundle: per-master request/lock/split lines, muxed transfer
// status, and the grant/owner outputs. The arbiter uses the slave modport.
interface ahb_bus_arbiter_if #(
    parameter int N_MASTERS = 4
);
    logic [N_MASTERS-1:0] HBUSREQ;
    logic [N_MASTERS-1:0] HLOCK;
    logic [1:0]           HTRANS;
    logic [2:0]           HBURST;
    logic                 HREADY;
    logic [1:0]           HRESP;
    logic [N_MASTERS-1:0] HSPLIT;
    logic [N_MASTERS-1:0] HGRANT;
    logic [3:0]           HMASTER;
    logic                 HMASTLOCK;

    modport slave (
        input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP, HSPLIT,
        output HGRANT, HMASTER, HMASTLOCK
    );

    modport master (
        output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP, HSPLIT,
        input  HGRANT, HMASTER, HMASTLOCK
    );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Multi-master AHB arbiter with burst, lock and SPLIT/RETRY tracking.
// Define AHB_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module ahb_bus_arbiter #(
    parameter int N_MASTERS  = 4,
    parameter int DEF_MASTER = 0
) (
    input  logic             HCLK,
    input  logic             HRESET,
    ahb_bus_arbiter_if.slave bus
);
    localparam int IW = 4;
    localparam logic [IW-1:0]        DEF_IDX    = IW'(DEF_MASTER);
    localparam logic [N_MASTERS-1:0] DEF_ONEHOT = N_MASTERS'(1'b1) << DEF_MASTER;

    localparam logic [1:0] TR_IDLE    = 2'b00;
    localparam logic [1:0] TR_NONSEQ  = 2'b10;
    localparam logic [1:0] TR_SEQ     = 2'b11;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_SPLIT = 2'b11;

    function automatic logic [IW-1:0] onehot_to_idx(input logic [N_MASTERS-1:0] oh);
        logic [IW-1:0] idx;
        idx = {IW{1'b0}};
        for (int k = 0; k < N_MASTERS; k++) begin
            if (oh[k]) idx = idx | IW'(k);
            else       idx = idx;
        end
        return idx;
    endfunction

    function automatic logic [N_MASTERS-1:0] idx_to_onehot(input logic [IW-1:0] idx);
        logic [N_MASTERS-1:0] oh;
        for (int k = 0; k < N_MASTERS; k++) oh[k] = (IW'(k) == idx);
        return oh;
    endfunction

    function automatic logic bit_at(input logic [N_MASTERS-1:0] vec, input logic [IW-1:0] idx);
        logic b;
        b = 1'b0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (IW'(k) == idx) b = vec[k];
            else               b = b;
        end
        return b;
    endfunction

    function automatic logic [IW-1:0] burst_beats(input logic [2:0] hburst);
        logic [IW-1:0] n;
        case (hburst)
            3'b010, 3'b011: n = 4'd3;
            3'b100, 3'b101: n = 4'd7;
            3'b110, 3'b111: n = 4'd15;
            default:        n = 4'd0;
        endcase
        return n;
    endfunction

    function automatic int wrap_idx(input int s);
        return (s >= N_MASTERS) ? s - N_MASTERS : s;
    endfunction

    logic [N_MASTERS-1:0] r_grant;
    logic [IW-1:0]        r_master;
    logic                 r_mastlock;
    logic [IW-1:0]        r_master_d;
    logic [N_MASTERS-1:0] r_split_mask;
    logic [IW-1:0]        r_beat_cnt;
    logic [IW-1:0]        r_rr_ptr;
    logic                 r_split_rearb;
    logic                 r_resp_seen;

    logic [N_MASTERS-1:0] w_eligible;
    logic [IW-1:0]        w_grant_idx;
    logic                 w_lock_hold;
    logic                 w_beat_ok;
    logic                 w_arb_ok;
    logic                 w_split_first;
    logic [IW-1:0]        w_next_idx;
    logic [IW-1:0]        w_beat_nxt;
    logic [N_MASTERS-1:0] w_mask_nxt;

    assign w_eligible    = bus.HBUSREQ & ~r_split_mask;
    assign w_grant_idx   = onehot_to_idx(r_grant);
    assign w_lock_hold   = r_mastlock & bit_at(bus.HLOCK, r_master);
    // The last SEQ beat's address phase is already an arbitration point.
    assign w_beat_ok     = (r_beat_cnt == 4'd0) | ((r_beat_cnt == 4'd1) & (bus.HTRANS == TR_SEQ));
    assign w_arb_ok      = bus.HREADY & (r_split_rearb | (~w_lock_hold & w_beat_ok));
    assign w_split_first = ~bus.HREADY & (bus.HRESP == RESP_SPLIT) & ~r_resp_seen;

    // Next-owner selection among eligible requesters, DEF_MASTER as fallback.
    always_comb begin
        w_next_idx = DEF_IDX;
`ifdef AHB_ARB_FIXED_PRIO_EN
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            if (w_eligible[k]) w_next_idx = IW'(k);
            else               w_next_idx = w_next_idx;
        end
`else
        for (int k = N_MASTERS; k >= 1; k--) begin
            if (bit_at(w_eligible, IW'(wrap_idx(int'(r_rr_ptr) + k)))) w_next_idx = IW'(wrap_idx(int'(r_rr_ptr) + k));
            else w_next_idx = w_next_idx;
        end
`endif
    end

    // Remaining-beat counter; any non-OKAY response abandons the burst.
    always_comb begin
        w_beat_nxt = r_beat_cnt;
        if (bus.HRESP != RESP_OKAY) begin
            w_beat_nxt = 4'd0;
        end else if (bus.HREADY) begin
            case (bus.HTRANS)
                TR_NONSEQ: w_beat_nxt = burst_beats(bus.HBURST);
                TR_SEQ:    w_beat_nxt = (r_beat_cnt == 4'd0) ? 4'd0 : r_beat_cnt - 4'd1;
                TR_IDLE:   w_beat_nxt = 4'd0;
                default:   w_beat_nxt = r_beat_cnt;
            endcase
        end else begin
            w_beat_nxt = r_beat_cnt;
        end
    end

    // Split mask: a new SPLIT on a bit beats a simultaneous release of it.
    always_comb begin
        w_mask_nxt = r_split_mask;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (w_split_first && (IW'(k) == r_master_d) && (k != DEF_MASTER)) w_mask_nxt[k] = 1'b1;
            else if (bus.HSPLIT[k])                                             w_mask_nxt[k] = 1'b0;
            else                                                                w_mask_nxt[k] = r_split_mask[k];
        end
    end

    // Arbitration state, grant, and address/data-phase ownership.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_grant       <= DEF_ONEHOT;
            r_master      <= DEF_IDX;
            r_mastlock    <= 1'b0;
            r_master_d    <= DEF_IDX;
            r_split_mask  <= {N_MASTERS{1'b0}};
            r_beat_cnt    <= 4'd0;
            r_rr_ptr      <= DEF_IDX;
            r_split_rearb <= 1'b0;
            r_resp_seen   <= 1'b0;
        end else begin
            r_split_mask <= w_mask_nxt;
            r_beat_cnt   <= w_beat_nxt;
            r_resp_seen  <= ~bus.HREADY & (bus.HRESP != RESP_OKAY);
            if (w_split_first)   r_split_rearb <= 1'b1;
            else if (bus.HREADY) r_split_rearb <= 1'b0;
            if (w_arb_ok) begin
                r_grant <= idx_to_onehot(w_next_idx);
                if (w_next_idx != w_grant_idx) r_rr_ptr <= w_next_idx;
            end
            if (bus.HREADY) begin
                r_master   <= w_grant_idx;
                r_mastlock <= bit_at(bus.HLOCK, w_grant_idx);
                r_master_d <= r_master;
            end else if (w_split_first) begin
                r_mastlock <= 1'b0;
            end
        end
    end

    assign bus.HGRANT    = r_grant;
    assign bus.HMASTER   = r_master;
    assign bus.HMASTLOCK = r_mastlock;
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter: vector table plus hand-built
// burst, lock, SPLIT, RETRY and mid-burst reset sequences through a scoreboard.
module tb_ahb_bus_arbiter;
    localparam int N = 4;
    localparam logic [1:0] IDLE = 2'b00, NS = 2'b10, SQ = 2'b11;
    localparam logic [1:0] OK = 2'b00, RTY = 2'b10, SPL = 2'b11;
    localparam logic [2:0] SGL = 3'b000, INC4 = 3'b011, INC8 = 3'b101;

    logic hclk = 1'b0;
    logic hreset;
    always #5 hclk = ~hclk;

    ahb_bus_arbiter_if #(.N_MASTERS(N)) bus ();
    ahb_bus_arbiter #(.N_MASTERS(N), .DEF_MASTER(0)) dut (.HCLK(hclk), .HRESET(hreset), .bus(bus));

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] lock;
        logic [1:0] tr;
        logic [2:0] bu;
        logic       rdy;
        logic [1:0] rsp;
        logic [3:0] spl;
        logic [3:0] e_grant;
        logic [3:0] e_master;
        logic       e_lock;
    } vec_t;

    typedef struct {
        logic [3:0] g;
        logic [3:0] m;
        logic       l;
        string      name;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_pass   = 0;

    function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic [3:0] lock,
                                input logic [1:0] tr, input logic [2:0] bu, input logic rdy,
                                input logic [1:0] rsp, input logic [3:0] spl,
                                input logic [3:0] eg, input logic [3:0] em, input logic el);
        vec_t v;
        v.rst = rst; v.req = req; v.lock = lock; v.tr = tr; v.bu = bu; v.rdy = rdy;
        v.rsp = rsp; v.spl = spl; v.e_grant = eg; v.e_master = em; v.e_lock = el;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard: no expected entry queued");
        end else begin
            e = sb.pop_front();
            chk({e.name, ".HGRANT"}, bus.HGRANT, e.g);
            chk({e.name, ".HMASTER"}, bus.HMASTER, e.m);
            chk({e.name, ".HMASTLOCK"}, {3'b000, bus.HMASTLOCK}, {3'b000, e.l});
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        exp_t e;
        hreset      = v.rst;
        bus.HBUSREQ = v.req;
        bus.HLOCK   = v.lock;
        bus.HTRANS  = v.tr;
        bus.HBURST  = v.bu;
        bus.HREADY  = v.rdy;
        bus.HRESP   = v.rsp;
        bus.HSPLIT  = v.spl;
        e.g = v.e_grant; e.m = v.e_master; e.l = v.e_lock; e.name = name;
        sb.push_back(e);
        @(posedge hclk);
        #1;
        check_out();
    endtask

    task automatic do_reset(input string name);
        apply(mk(1'b1, 4'b0000, 4'b0000, IDLE, SGL, 1'b1, OK, 4'b0000, 4'b0001, 4'd0, 1'b0), name);
    endtask

    vec_t tbl[11];

    initial begin
        // reset then idle, followed by two requesters with single transfers
        tbl[0] = mk(1'b1, 4'b0000, 4'b0000, IDLE, SGL, 1'b1, OK, 4'b0000, 4'b0001, 4'd0, 1'b0);
        for (int i = 1; i <= 5; i++)
            tbl[i] = mk(1'b0, 4'b0000, 4'b0000, IDLE, SGL, 1'b1, OK, 4'b0000, 4'b0001, 4'd0, 1'b0);
`ifdef AHB_ARB_FIXED_PRIO_EN
        for (int i = 6; i <= 10; i++)
            tbl[i] = mk(1'b0, 4'b0101, 4'b0000, NS, SGL, 1'b1, OK, 4'b0000, 4'b0001, 4'd0, 1'b0);
`else
        tbl[6]  = mk(1'b0, 4'b0101, 4'b0000, NS, SGL, 1'b1, OK, 4'b0000, 4'b0100, 4'd0, 1'b0);
        tbl[7]  = mk(1'b0, 4'b0101, 4'b0000, NS, SGL, 1'b1, OK, 4'b0000, 4'b0001, 4'd2, 1'b0);
        tbl[8]  = mk(1'b0, 4'b0101, 4'b0000, NS, SGL, 1'b1, OK, 4'b0000, 4'b0100, 4'd0, 1'b0);
        tbl[9]  = mk(1'b0, 4'b0101, 4'b0000, NS, SGL, 1'b1, OK, 4'b0000, 4'b0001, 4'd2, 1'b0);
        tbl[10] = mk(1'b0, 4'b0101, 4'b0000, NS, SGL, 1'b1, OK, 4'b0000, 4'b0100, 4'd0, 1'b0);
`endif
        #2;
        for (int i = 0; i < 11; i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // INCR4 by master 1 with a wait state; handover on last-beat address phase
        do_reset("burst.rst");
        apply(mk(1'b0, 4'b0010, 4'b0000, IDLE, SGL, 1'b1, OK, 4'b0000, 4'b0010, 4'd0, 1'b0), "burst.g1");
        apply(mk(1'b0, 4'b0010, 4'b0000, IDLE, SGL, 1'b1, OK, 4'b0000, 4'b0010, 4'd1, 1'b0), "burst.own1");
        apply(mk(1'b0, 4'b0010, 4'b0000, NS,  INC4, 1'b1, OK, 4'b0000, 4'b0010, 4'd1, 1'b0), "burst.b1");
        apply(mk(1'b0, 4'b0110, 4'b0000, SQ,  INC4, 1'b1, OK, 4'b0000, 4'b0010, 4'd1, 1'b0), "burst.b2");
        apply(mk(1'b0, 4'b0110, 4'b0000, SQ,  INC4, 1'b0, OK, 4'b0000, 4'b0010, 4'd1, 1'b0), "burst.wait");
        apply(mk(1'b0, 4'b0110, 4'b0000, SQ,  INC4, 1'b1, OK, 4'b0000, 4'b0010, 4'd1, 1'b0), "burst.b3");
        apply(mk(1'b0, 4'b0100, 4'b0000, SQ,  INC4, 1'b1, OK, 4'b0000, 4'b0100, 4'd1, 1'b0), "burst.b4");
        apply(mk(1'b0, 4'b0100, 4'b0000, IDLE, SGL, 1'b1, OK, 4'b0000, 4'b0100, 4'd2, 1'b0), "burst.own2");

        // locked sequence by master 3 blocks master 1 until HLOCK drops
        do_reset("lock.rst");
        apply(mk(1'b0, 4'b1000, 4'b1000, IDLE, SGL, 1'b1, OK, 4'b0000, 4'b1000, 4'd0, 1'b0), "lock.g3");
        apply(mk(1'b0, 4'b1000, 4'b1000, NS,  SGL, 1'b1, OK, 4'b0000, 4'b1000, 4'd3, 1'b1), "lock.own3");
        apply(mk(1'b0, 4'b1010, 4'b1000, NS,  SGL, 1'b1, OK, 4'b0000, 4'b1000, 4'd3, 1'b1), "lock.hold1");
        apply(mk(1'b0, 4'b1010, 4'b1000, NS,  SGL, 1'b0, OK, 4'b0000, 4'b1000, 4'd3, 1'b1), "lock.wait");
        apply(mk(1'b0, 4'b1010, 4'b1000, NS,  SGL, 1'b1, OK, 4'b0000, 4'b1000, 4'd3, 1'b1), "lock.hold2");
        apply(mk(1'b0, 4'b0010, 4'b0000, IDLE, SGL, 1'b0, OK, 4'b0000, 4'b1000, 4'd3, 1'b1), "lock.relwait");
        apply(mk(1'b0, 4'b0010, 4'b0000, IDLE, SGL, 1'b1, OK, 4'b0000, 4'b0010, 4'd3, 1'b0), "lock.g1");
        apply(mk(1'b0, 4'b0010, 4'b0000, IDLE, SGL, 1'b1, OK, 4'b0000, 4'b0010, 4'd1, 1'b0), "lock.own1");

        // SPLIT of master 2, masked while requesting, released by HSPLIT
        do_reset("split.rst");
        apply(mk(1'b0, 4'b0100, 4'b0000, IDLE, SGL, 1'b1, OK,  4'b0000, 4'b0100, 4'd0, 1'b0), "split.g2");
        apply(mk(1'b0, 4'b0100, 4'b0000, IDLE, SGL, 1'b1, OK,  4'b0000, 4'b0100, 4'd2, 1'b0), "split.own2");
        apply(mk(1'b0, 4'b0100, 4'b0000, NS,   SGL, 1'b1, OK,  4'b0000, 4'b0100, 4'd2, 1'b0), "split.addr");
        apply(mk(1'b0, 4'b0100, 4'b0000, IDLE, SGL, 1'b0, SPL, 4'b0000, 4'b0100, 4'd2, 1'b0), "split.c1");
        apply(mk(1'b0, 4'b0100, 4'b0000, IDLE, SGL, 1'b1, SPL, 4'b0000, 4'b0001, 4'd2, 1'b0), "split.c2");
        apply(mk(1'b0, 4'b0100, 4'b0000, IDLE, SGL, 1'b1, OK,  4'b0000, 4'b0001, 4'd0, 1'b0), "split.masked1");
        apply(mk(1'b0, 4'b0100, 4'b0000, IDLE, SGL, 1'b1, OK,  4'b0000, 4'b0001, 4'd0, 1'b0), "split.masked2");
        apply(mk(1'b0, 4'b0100, 4'b0000, IDLE, SGL, 1'b1, OK,  4'b0100, 4'b0001, 4'd0, 1'b0), "split.release");
        apply(mk(1'b0, 4'b0100, 4'b0000, IDLE, SGL, 1'b1, OK,  4'b0000, 4'b0100, 4'd0, 1'b0), "split.regrant");
        apply(mk(1'b0, 4'b0100, 4'b0000, IDLE, SGL, 1'b1, OK,  4'b0000, 4'b0100, 4'd2, 1'b0), "split.own2b");

        // RETRY mid-INCR4 drops the burst hold so the grant can move at once
        do_reset("retry.rst");
        apply(mk(1'b0, 4'b0010, 4'b0000, IDLE, SGL,  1'b1, OK,  4'b0000, 4'b0010, 4'd0, 1'b0), "retry.g1");
        apply(mk(1'b0, 4'b0010, 4'b0000, IDLE, SGL,  1'b1, OK,  4'b0000, 4'b0010, 4'd1, 1'b0), "retry.own1");
        apply(mk(1'b0, 4'b0010, 4'b0000, NS,   INC4, 1'b1, OK,  4'b0000, 4'b0010, 4'd1, 1'b0), "retry.b1");
        apply(mk(1'b0, 4'b0100, 4'b0000, IDLE, INC4, 1'b0, RTY, 4'b0000, 4'b0010, 4'd1, 1'b0), "retry.c1");
        apply(mk(1'b0, 4'b0100, 4'b0000, IDLE, INC4, 1'b1, RTY, 4'b0000, 4'b0100, 4'd1, 1'b0), "retry.c2");

        // reset in the middle of INCR8 leaves no burst hold behind
        do_reset("mid.rst0");
        apply(mk(1'b0, 4'b0010, 4'b0000, IDLE, SGL,  1'b1, OK, 4'b0000, 4'b0010, 4'd0, 1'b0), "mid.g1");
        apply(mk(1'b0, 4'b0010, 4'b0000, IDLE, SGL,  1'b1, OK, 4'b0000, 4'b0010, 4'd1, 1'b0), "mid.own1");
        apply(mk(1'b0, 4'b0010, 4'b0000, NS,   INC8, 1'b1, OK, 4'b0000, 4'b0010, 4'd1, 1'b0), "mid.b1");
        apply(mk(1'b0, 4'b0110, 4'b0000, SQ,   INC8, 1'b1, OK, 4'b0000, 4'b0010, 4'd1, 1'b0), "mid.b2");
        apply(mk(1'b0, 4'b0110, 4'b0000, SQ,   INC8, 1'b1, OK, 4'b0000, 4'b0010, 4'd1, 1'b0), "mid.b3");
        apply(mk(1'b1, 4'b0110, 4'b0000, SQ,   INC8, 1'b1, OK, 4'b0000, 4'b0001, 4'd0, 1'b0), "mid.reset");
        apply(mk(1'b0, 4'b0100, 4'b0000, SQ,   INC8, 1'b1, OK, 4'b0000, 4'b0100, 4'd0, 1'b0), "mid.arb");
        apply(mk(1'b0, 4'b0100, 4'b0000, IDLE, SGL,  1'b1, OK, 4'b0000, 4'b0100, 4'd2, 1'b0), "mid.own2");

        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
Multi-master AHB arbiter for the shared AHB-Lite fabric. It takes per-master HBUSREQ/HLOCK and drives HGRANT, HMASTER and HMASTLOCK. It tracks fixed-length bursts, locked sequences and SPLIT/RETRY responses. It sits beside the address/data muxes, and its HMASTER output selects the master whose HTRANS/HADDR/HWDATA reach the slaves.

Parameters:
N_MASTERS, 4, number of masters (2..8); width of HBUSREQ/HLOCK/HGRANT/HSPLIT.
DEF_MASTER, 0, default master index; granted when nobody eligible requests; never SPLIT by slaves.

Ports:
HCLK  in  1  system clock, all state on rising edge
HRESET  in  1  synchronous, active-high reset
HBUSREQ  in  N_MASTERS  per-master bus request
HLOCK  in  N_MASTERS  per-master locked-transfer request
HTRANS  in  2  muxed transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
HBURST  in  3  muxed burst type
HREADY  in  1  muxed slave ready
HRESP  in  2  muxed response (OKAY=00, ERROR=01, RETRY=10, SPLIT=11)
HSPLIT  in  N_MASTERS  OR of slave split-release vectors; bit i releases master i
HGRANT  out  N_MASTERS  one-hot grant
HMASTER  out  4  index of the address-phase owner
HMASTLOCK  out  1  current address phase is locked

Behaviour:
- Reset (HRESET=1 at an edge): HGRANT=1<<DEF_MASTER, HMASTER=DEF_MASTER, HMASTLOCK=0, split_mask=0, beat_cnt=0, rr_ptr=DEF_MASTER.
- eligible = HBUSREQ & ~split_mask.
- Next-grant selection uses round-robin: scan eligible from rr_ptr+1, wrapping modulo N_MASTERS. If no bit is set, select DEF_MASTER.
- beat_cnt is updated on edges with HREADY=1:
  - NONSEQ with INCR4/WRAP4 loads 3; INCR8/WRAP8 loads 7; INCR16/WRAP16 loads 15.
  - NONSEQ with SINGLE/INCR loads 0.
  - SEQ decrements, saturating at 0.
  - IDLE clears to 0. BUSY holds.
- arb_ok = HREADY & ~lock_hold & (beat_cnt==0 | (beat_cnt==1 & HTRANS==SEQ)). This allows the grant to move during the address phase of the last beat.
- Undefined-length INCR is re-arbitrable on every HREADY.
- lock_hold = HMASTLOCK & HLOCK[HMASTER].
- When arb_ok=1 at an edge:
  - HGRANT <= one-hot(next).
  - rr_ptr <= next only if next != current owner; a re-grant keeps the pointer.
- Ownership handover: HMASTER <= index of HGRANT, and HMASTLOCK <= HLOCK[index of HGRANT]. Both update at the first HREADY=1 edge after HGRANT changed, i.e. one cycle after the grant change, in the new owner's first address phase.
- Data-phase owner: an internal register, HMASTER_d <= HMASTER on HREADY=1 edges.
- SPLIT, detected on the first cycle HRESP=11 & HREADY=0:
  - Set split_mask[HMASTER_d].
  - Force beat_cnt=0 and clear HMASTLOCK.
  - Re-arbitrate at the following HREADY=1 edge, ignoring the burst hold and lock hold.
- RETRY (first cycle HRESP=10 & HREADY=0): force beat_cnt=0; no mask change; the master keeps priority via normal round-robin.
- ERROR: force beat_cnt=0; grant unaffected.
- HSPLIT[i]=1 clears split_mask[i] at that edge. If a set and a clear hit the same bit in the same cycle, the set wins.
- All non-default masters split: DEF_MASTER is granted and must drive IDLE.
- Grant is never withdrawn from a master while HREADY=0; HGRANT and HMASTER are stable across wait states.
- Reset mid-burst: immediate return to reset values at the next edge; no partial state retained.

Optional Feature:
AHB_ARB_FIXED_PRIO_EN:
- Defined: next-grant selection is fixed priority, lowest index first among eligible. rr_ptr is still maintained but unused.
- Undefined: round-robin as above.
- All other rules (bursts, lock, SPLIT) are identical in both modes.

Test Plan:
- Reset, then HBUSREQ=0000 for 5 cycles -> HGRANT=0001, HMASTER=0, HMASTLOCK=0 throughout.
- HBUSREQ=0101 held, every master issues SINGLE NONSEQ with HREADY=1 -> grant alternates 0001,0100,0001,...; HMASTER follows one cycle later. With AHB_ARB_FIXED_PRIO_EN -> HGRANT stays 0001.
- Master 1 owns the bus and issues INCR4 NONSEQ+3 SEQ; master 2 requests from beat 1; one HREADY=0 wait state on beat 2 -> HGRANT stays 0010 until the beat-4 address phase, then becomes 0100. Master 2 is HMASTER on the next HREADY edge.
- Master 3 asserts HLOCK with HBUSREQ=1000; master 1 also requests -> HMASTLOCK=1 and no grant change until HLOCK[3]=0 and the current transfer completes; then HGRANT=0010.
- Master 2 in data phase gets HRESP=11 for two cycles (HREADY 0 then 1) -> split_mask=0100, grant moves away from master 2. With HBUSREQ[2] still high it is not re-granted. HSPLIT=0100 for one cycle -> mask clears, and master 2 is granted at the next arbitration point.
- Assert HRESET mid-INCR8 at beat 3 -> next edge HGRANT=0001, HMASTER=0, beat_cnt=0, split_mask=0.
